// File: rtl/datapath_run_pkg.sv
// Shared types for the Datapath run controller: FSM state encoding and the
// width helper for a {PC, Reg_Write} trace entry.
package datapath_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_e;

  localparam int RUN_IDX_W = 8;

  function automatic int trace_w(input int pc_w, input int data_w);
    return pc_w + data_w;
  endfunction

endpackage

// File: rtl/datapath_run_ctrl_if.sv
// Control/observe bundle between the run controller (slave) and whoever
// drives Start/Abort and feeds the Datapath PC and write-back data (master).
interface datapath_run_ctrl_if
  import datapath_run_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int TRACE_DEPTH = 16
);
  localparam int TRACE_W = trace_w(PC_W, DATA_W);
  localparam int TA_W    = $clog2(TRACE_DEPTH);

  logic                 Start;
  logic                 Abort;
  logic [PC_W-1:0]      PC_Counter;
  logic [DATA_W-1:0]    Reg_Write;
  logic                 Dp_Reset;
  logic                 Busy;
  logic                 Done;
  logic                 Halted;
  logic [CNT_W-1:0]     Cycle_Count;
  logic [RUN_IDX_W-1:0] Run_Index;
  logic [TA_W-1:0]      Trace_Rd_Addr;
  logic [TRACE_W-1:0]   Trace_Rd_Data;
  logic [TA_W:0]        Trace_Count;

  modport master (
    output Start, Abort, PC_Counter, Reg_Write, Trace_Rd_Addr,
    input  Dp_Reset, Busy, Done, Halted, Cycle_Count, Run_Index,
           Trace_Rd_Data, Trace_Count
  );

  modport slave (
    input  Start, Abort, PC_Counter, Reg_Write, Trace_Rd_Addr,
    output Dp_Reset, Busy, Done, Halted, Cycle_Count, Run_Index,
           Trace_Rd_Data, Trace_Count
  );

endinterface

// File: rtl/run_trace_buf.sv
// Circular trace of the newest DEPTH entries with a saturating fill count;
// reads are relative to the oldest valid entry.
module run_trace_buf #(
  parameter int   W     = 64,
  parameter int   DEPTH = 16,
  localparam int  AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   count_q;
  logic          full;
  logic [AW-1:0] oldest;

  assign full   = (count_q == FULL_CNT);
  assign oldest = full ? wr_ptr_q : '0;

  // NOTE: the storage array has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (wr_en_i) begin
      wr_ptr_q <= wr_ptr_q + AW'(1);
      if (!full) count_q <= count_q + (AW+1)'(1);
    end
  end

  // Power-of-two depth lets the pointer add wrap on its own.
  assign rd_data_o = mem_q[oldest + rd_addr_i];
  assign count_o   = count_q;

endmodule

// File: rtl/datapath_run_ctrl.sv
// Run controller for the MIPS Datapath: reset hold, run until PC halt or budget
// timeout, optional back-to-back runs. Optional trace under DP_RUN_TRACE_EN.
module datapath_run_ctrl
  import datapath_run_pkg::*;
#(
  parameter int PC_W           = 32,
  parameter int DATA_W         = 32,
  parameter int CNT_W          = 16,
  parameter int HOLD_CYCLES    = 5,
  parameter int MAX_RUN_CYCLES = 135,
  parameter int HALT_STABLE    = 4,
  parameter int RUNS           = 1,
  parameter int TRACE_DEPTH    = 16
) (
  input logic                Clk,
  input logic                Reset,
  datapath_run_ctrl_if.slave bus
);

  localparam int TRACE_W = trace_w(PC_W, DATA_W);
  localparam int TA_W    = $clog2(TRACE_DEPTH);
  localparam int HC_W    = $clog2(HOLD_CYCLES + 1);
  localparam int HS_W    = $clog2(HALT_STABLE + 1);

  localparam logic [HC_W-1:0]      HOLD_LAST   = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HS_W-1:0]      STABLE_LAST = HS_W'(HALT_STABLE - 1);
  localparam logic [CNT_W-1:0]     CNT_SAT     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]     RUN_LIMIT   = CNT_W'(MAX_RUN_CYCLES);
  localparam logic [RUN_IDX_W-1:0] RUN_LAST    = RUN_IDX_W'(RUNS - 1);

  run_state_e           state_q;
  logic                 dp_reset_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 halted_q;
  logic [CNT_W-1:0]     cycle_cnt_q;
  logic [RUN_IDX_W-1:0] run_idx_q;
  logic [HC_W-1:0]      hold_cnt_q;
  logic [PC_W-1:0]      pc_prev_q;
  logic                 prev_valid_q;
  logic [HS_W-1:0]      stable_q;

  logic [CNT_W-1:0] cnt_inc;
  logic             pc_same;
  logic             halt_hit;
  logic             timeout_hit;

  assign cnt_inc     = (cycle_cnt_q == CNT_SAT) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
  // The first RUN cycle has no previous PC, so it can never count as stable.
  assign pc_same     = prev_valid_q && (bus.PC_Counter == pc_prev_q);
  assign halt_hit    = pc_same && (stable_q == STABLE_LAST);
  assign timeout_hit = (cnt_inc == RUN_LIMIT);

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch sees the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      dp_reset_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      halted_q     <= 1'b0;
      cycle_cnt_q  <= '0;
      run_idx_q    <= '0;
      hold_cnt_q   <= '0;
      pc_prev_q    <= '0;
      prev_valid_q <= 1'b0;
      stable_q     <= '0;
    end else if (bus.Abort && (state_q != ST_IDLE)) begin
      state_q    <= ST_IDLE;
      dp_reset_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.Start) begin
            state_q     <= ST_HOLD;
            busy_q      <= 1'b1;
            cycle_cnt_q <= '0;
            run_idx_q   <= '0;
            halted_q    <= 1'b0;
            hold_cnt_q  <= '0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q      <= ST_RUN;
            dp_reset_q   <= 1'b0;
            prev_valid_q <= 1'b0;
            stable_q     <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HC_W'(1);
          end
        end
        ST_RUN: begin
          cycle_cnt_q  <= cnt_inc;
          pc_prev_q    <= bus.PC_Counter;
          prev_valid_q <= 1'b1;
          stable_q     <= pc_same ? stable_q + HS_W'(1) : '0;
          if (halt_hit || timeout_hit) begin
            halted_q   <= halt_hit;
            dp_reset_q <= 1'b1;
            if (run_idx_q < RUN_LAST) begin
              run_idx_q   <= run_idx_q + RUN_IDX_W'(1);
              cycle_cnt_q <= '0;
              hold_cnt_q  <= '0;
              state_q     <= ST_HOLD;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.Dp_Reset    = dp_reset_q;
  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
  assign bus.Halted      = halted_q;
  assign bus.Cycle_Count = cycle_cnt_q;
  assign bus.Run_Index   = run_idx_q;

`ifdef DP_RUN_TRACE_EN
  logic trace_clr;
  logic trace_we;

  assign trace_clr = (state_q == ST_IDLE) && bus.Start;
  assign trace_we  = (state_q == ST_RUN) && !bus.Abort && !pc_same;

  run_trace_buf #(
    .W     (TRACE_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk       (Clk),
    .rst_n     (Reset),
    .clr_i     (trace_clr),
    .wr_en_i   (trace_we),
    .wr_data_i ({bus.PC_Counter, bus.Reg_Write}),
    .rd_addr_i (bus.Trace_Rd_Addr),
    .rd_data_o (bus.Trace_Rd_Data),
    .count_o   (bus.Trace_Count)
  );
`else
  logic unused_trace;

  assign unused_trace      = ^{bus.Trace_Rd_Addr, bus.Reg_Write};
  assign bus.Trace_Rd_Data = {TRACE_W{1'b0}};
  assign bus.Trace_Count   = {(TA_W + 1){1'b0}};
`endif

endmodule

// File: tb/tb_datapath_run_ctrl.sv
// Directed bench for datapath_run_ctrl: one instance with a single run per Start,
// one with three back-to-back runs, sharing clock and reset.
module tb_datapath_run_ctrl;

  localparam int PC_W        = 32;
  localparam int DATA_W      = 32;
  localparam int CNT_W       = 16;
  localparam int TRACE_DEPTH = 16;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  int n_checks   = 0;
  int n_fails    = 0;
  int done_a_cnt = 0;
  int done_b_cnt = 0;

  datapath_run_ctrl_if #(.PC_W(PC_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .TRACE_DEPTH(TRACE_DEPTH)) if_a ();
  datapath_run_ctrl_if #(.PC_W(PC_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .TRACE_DEPTH(TRACE_DEPTH)) if_b ();

  datapath_run_ctrl #(
    .PC_W(PC_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .HOLD_CYCLES(5), .MAX_RUN_CYCLES(135),
    .HALT_STABLE(4), .RUNS(1), .TRACE_DEPTH(TRACE_DEPTH)
  ) u_dut_a (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (if_a)
  );

  datapath_run_ctrl #(
    .PC_W(PC_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .HOLD_CYCLES(5), .MAX_RUN_CYCLES(135),
    .HALT_STABLE(4), .RUNS(3), .TRACE_DEPTH(TRACE_DEPTH)
  ) u_dut_b (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (if_b)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
    done_a_cnt += int'(if_a.Done);
    done_b_cnt += int'(if_b.Done);
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) if_b.Start = 1'b1;
    else     if_a.Start = 1'b1;
    tick();
    if_a.Start = 1'b0;
    if_b.Start = 1'b0;
  endtask

  task automatic measure_hold(input bit sel, output int len);
    len = 0;
    while (len < 50 && (sel ? (if_b.Busy && if_b.Dp_Reset) : (if_a.Busy && if_a.Dp_Reset))) begin
      len++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int c;
    int base;

    if_a.Start = 1'b0; if_a.Abort = 1'b0; if_a.PC_Counter = '0; if_a.Reg_Write = '0; if_a.Trace_Rd_Addr = '0;
    if_b.Start = 1'b0; if_b.Abort = 1'b0; if_b.PC_Counter = '0; if_b.Reg_Write = '0; if_b.Trace_Rd_Addr = '0;

    // Reset values
    #3 Reset = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_dp_reset", if_a.Dp_Reset, 1);
    check("rst_busy", if_a.Busy, 0);
    check("rst_done", if_a.Done, 0);
    check("rst_halted", if_a.Halted, 0);
    check("rst_cycle_cnt", if_a.Cycle_Count, 0);
    check("rst_run_idx", if_a.Run_Index, 0);
    check("rst_trace_cnt", if_a.Trace_Count, 0);
    Reset = 1'b1;
    tick();
    check("idle_dp_reset", if_a.Dp_Reset, 1);

    // 1: PC keeps incrementing, run ends on the 135-cycle budget
    pulse_start(1'b0);
    measure_hold(1'b0, len);
    check("t1_hold_len", len, 5);
    c = 0;
    while (c < 300 && if_a.Busy && !if_a.Dp_Reset) begin
      c++;
      if_a.PC_Counter = 32'(4 * c);
      if_a.Reg_Write  = 32'(c);
      tick();
      if (c == 10) check("t1_cnt_mid", if_a.Cycle_Count, 10);
    end
    check("t1_run_len", c, 135);
    check("t1_done", if_a.Done, 1);
    check("t1_halted", if_a.Halted, 0);
    check("t1_cycle_cnt", if_a.Cycle_Count, 135);
    check("t1_dp_reset", if_a.Dp_Reset, 1);
    check("t1_busy", if_a.Busy, 0);
    tick();
    check("t1_done_drop", if_a.Done, 0);
    check("t1_done_pulses", done_a_cnt, 1);
`ifndef DP_RUN_TRACE_EN
    if_a.Trace_Rd_Addr = 4'd0;
    #1 check("t1_trace_data0", if_a.Trace_Rd_Data, 0);
    if_a.Trace_Rd_Addr = 4'd5;
    #1 check("t1_trace_data5", if_a.Trace_Rd_Data, 0);
    check("t1_trace_cnt", if_a.Trace_Count, 0);
    @(negedge Clk);
`endif

    // 2: PC equals its previous value from run cycle 20 onward -> halt after 4 stable cycles
    pulse_start(1'b0);
    measure_hold(1'b0, len);
    check("t2_hold_len", len, 5);
    c = 0;
    while (c < 300 && if_a.Busy && !if_a.Dp_Reset) begin
      c++;
      if_a.PC_Counter = (c < 19) ? 32'(32'h1000 + 4 * c) : 32'h0000_0040;
      tick();
    end
    check("t2_run_len", c, 23);
    check("t2_done", if_a.Done, 1);
    check("t2_halted", if_a.Halted, 1);
    check("t2_cycle_cnt", if_a.Cycle_Count, 23);
    check("t2_run_idx", if_a.Run_Index, 0);
    tick();
    check("t2_done_pulses", done_a_cnt, 2);

    // 3: three back-to-back runs on the RUNS=3 instance, PC constant -> each halts at cycle 5
    pulse_start(1'b1);
    for (int r = 0; r < 3; r++) begin
      measure_hold(1'b1, len);
      check("t3_hold_len", len, 5);
      check("t3_run_idx", if_b.Run_Index, r);
      c = 0;
      while (c < 300 && if_b.Busy && !if_b.Dp_Reset) begin
        c++;
        if_b.PC_Counter = 32'h0000_0080;
        tick();
      end
      check("t3_run_len", c, 5);
      check("t3_halted", if_b.Halted, 1);
      if (r < 2) begin
        check("t3_gap_dp_reset", if_b.Dp_Reset, 1);
        check("t3_gap_cycle_cnt", if_b.Cycle_Count, 0);
        check("t3_gap_done", if_b.Done, 0);
      end
    end
    check("t3_last_done", if_b.Done, 1);
    check("t3_last_cycle_cnt", if_b.Cycle_Count, 5);
    repeat (3) tick();
    check("t3_done_pulses", done_b_cnt, 1);
    check("t3_final_idx", if_b.Run_Index, 2);

    // 4: Abort while Cycle_Count shows 50
    base = done_a_cnt;
    pulse_start(1'b0);
    measure_hold(1'b0, len);
    for (int i = 1; i <= 50; i++) begin
      if_a.PC_Counter = 32'(32'h4000 + 4 * i);
      tick();
    end
    check("t4_pre_abort_cnt", if_a.Cycle_Count, 50);
    if_a.Abort = 1'b1;
    tick();
    if_a.Abort = 1'b0;
    check("t4_busy", if_a.Busy, 0);
    check("t4_dp_reset", if_a.Dp_Reset, 1);
    check("t4_cycle_cnt", if_a.Cycle_Count, 50);
    repeat (3) tick();
    check("t4_no_done", done_a_cnt - base, 0);
    check("t4_still_idle", if_a.Busy, 0);
    check("t4_cnt_hold", if_a.Cycle_Count, 50);

    // 5: Reset mid-RUN clears both instances immediately, then a normal run
    pulse_start(1'b0);
    measure_hold(1'b0, len);
    for (int i = 1; i <= 30; i++) begin
      if_a.PC_Counter = 32'(32'h8000 + 4 * i);
      tick();
    end
    check("t5_running", if_a.Dp_Reset, 0);
    #2 Reset = 1'b0;
    #1;
    check("t5_dp_reset", if_a.Dp_Reset, 1);
    check("t5_busy", if_a.Busy, 0);
    check("t5_cycle_cnt", if_a.Cycle_Count, 0);
    check("t5_b_halted", if_b.Halted, 0);
    check("t5_b_run_idx", if_b.Run_Index, 0);
    check("t5_b_cycle_cnt", if_b.Cycle_Count, 0);
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    base = done_a_cnt;
    pulse_start(1'b0);
    measure_hold(1'b0, len);
    check("t5_hold_len", len, 5);
    c = 0;
    while (c < 300 && if_a.Busy && !if_a.Dp_Reset) begin
      c++;
      if_a.PC_Counter = 32'h0000_0100;
      tick();
    end
    check("t5_run_len", c, 5);
    check("t5_done", if_a.Done, 1);
    check("t5_halted", if_a.Halted, 1);
    tick();
    check("t5_done_pulses", done_a_cnt - base, 1);

    // 6: trace buffer
`ifdef DP_RUN_TRACE_EN
    pulse_start(1'b0);
    measure_hold(1'b0, len);
    c = 0;
    while (c < 300 && if_a.Busy && !if_a.Dp_Reset) begin
      c++;
      if_a.PC_Counter = (c <= 20) ? 32'(32'h2000 + 4 * c) : 32'h0000_2050;
      if_a.Reg_Write  = (c <= 20) ? 32'(32'hA000_0000 + c) : 32'h0000_DEAD;
      tick();
    end
    check("t6_run_len", c, 24);
    check("t6_trace_cnt", if_a.Trace_Count, 16);
    if_a.Trace_Rd_Addr = 4'd0;
    #1 check("t6_trace_oldest", if_a.Trace_Rd_Data, {32'h0000_2014, 32'hA000_0005});
    if_a.Trace_Rd_Addr = 4'd15;
    #1 check("t6_trace_newest", if_a.Trace_Rd_Data, {32'h0000_2050, 32'hA000_0014});
    @(negedge Clk);
`else
    if_a.Trace_Rd_Addr = 4'd15;
    #1 check("t6_trace_data15", if_a.Trace_Rd_Data, 0);
    check("t6_trace_cnt", if_a.Trace_Count, 0);
    @(negedge Clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
